cpu_exec_ctrl: RTL and testbench

- Execution sequencer for the single-cycle CPU top.
- Converts the board run switch and step button into a one-cycle CPU clock-enable (cpu_ce), from the 100 MHz board clk.
- Free-run mode at a divided rate, single-step mode, halt on CPU halt request, optional PC breakpoint.
- Sits between board I/O and the CPU core; exports state and executed-cycle count to the seven-segment display mux.

---
 rtl/cpu_exec_ctrl.sv | 115 +++++++++++
 tb/tb_cpu_exec_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: run/step/halt sequencer producing a one-cycle CPU clock-enable.
// Optional PC breakpoint enabled by defining BREAKPOINT_EN.
module cpu_exec_ctrl #(
    parameter int DBNC_CYCLES = 20000,
    parameter int RUN_DIV     = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             busy
);
    localparam int DW = $clog2(DBNC_CYCLES + 1);
    localparam int VW = $clog2(RUN_DIV);

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} st_t;

    st_t st;
    logic run_m, run_s, step_m, step_s, step_lvl, step_pulse;
    logic [DW-1:0] dbnc_cnt;
    logic [VW-1:0] div_cnt;
    logic tick, bp_hit, dbnc_done;

    assign tick      = div_cnt == VW'(RUN_DIV - 1);
    assign dbnc_done = (step_s != step_lvl) && dbnc_cnt == DW'(DBNC_CYCLES - 1);
    assign state     = st;
    assign busy      = st == RUN || st == STEP;

`ifdef BREAKPOINT_EN
    logic skip_bp;
    // skip_bp lets a resume execute the instruction it halted on
    assign bp_hit = tick && bp_valid && pc == bp_addr && !skip_bp;
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_m      <= 1'b0;
            run_s      <= 1'b0;
            step_m     <= 1'b0;
            step_s     <= 1'b0;
            step_lvl   <= 1'b0;
            step_pulse <= 1'b0;
            dbnc_cnt   <= '0;
        end else begin
            run_m      <= run;
            run_s      <= run_m;
            step_m     <= step;
            step_s     <= step_m;
            dbnc_cnt   <= (step_s == step_lvl || dbnc_done) ? '0 : dbnc_cnt + 1'b1;
            step_lvl   <= dbnc_done ? step_s : step_lvl;
            step_pulse <= dbnc_done && step_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            cpu_ce    <= 1'b0;
            cycle_cnt <= '0;
            div_cnt   <= '0;
`ifdef BREAKPOINT_EN
            skip_bp   <= 1'b0;
`endif
        end else begin
            cpu_ce    <= 1'b0;
            cycle_cnt <= cycle_cnt + CNT_W'(cpu_ce);
            case (st)
                IDLE: begin
                    if (run_s) begin
                        st      <= RUN;
                        div_cnt <= '0;
`ifdef BREAKPOINT_EN
                        skip_bp <= 1'b1;
`endif
                    end else if (step_pulse) begin
                        st     <= STEP;
                        cpu_ce <= 1'b1;
                    end
                end
                RUN: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (halt_req) st <= HALT;
                    else if (!run_s) st <= IDLE;
                    else if (bp_hit) st <= HALT;
                    else if (tick) begin
                        cpu_ce  <= 1'b1;
`ifdef BREAKPOINT_EN
                        skip_bp <= 1'b0;
`endif
                    end
                end
                STEP: st <= IDLE;
                HALT: begin
                    if (!run_s) st <= IDLE;
                    else if (step_pulse) begin
                        st     <= STEP;
                        cpu_ce <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// tb_cpu_exec_ctrl: bench for cpu_exec_ctrl with DBNC_CYCLES=4, RUN_DIV=4, CNT_W=4.
module tb_cpu_exec_ctrl;
    logic clk = 0, reset = 1, run = 0, step = 0, halt_req = 0, bp_valid = 0;
    logic [31:0] pc = 0, bp_addr = 0;
    logic cpu_ce, busy;
    logic [1:0] state;
    logic [3:0] cycle_cnt;

    int n_tests = 0, n_fail = 0;
    typedef struct {logic [1:0] st; logic [3:0] cnt;} exp_t;
    typedef struct {int bounces; int hold; int exp_n;} vec_t;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[4];
    logic [3:0] model_cnt = 0;
    logic prev_ce = 0;

    cpu_exec_ctrl #(.DBNC_CYCLES(4), .RUN_DIV(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
        .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .cpu_ce(cpu_ce), .state(state), .cycle_cnt(cycle_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_pulses(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{s, model_cnt});
            model_cnt++;
        end
    endtask

    task automatic sb_empty(input string nm);
        chk(nm, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim, input string nm);
        for (int i = 0; i < lim && state != s; i++) @(negedge clk);
        chk(nm, state, s);
    endtask

    task automatic press(input int bounces, input int hold);
        for (int b = 0; b < bounces; b++) begin
            step = 1; repeat (3) @(negedge clk);
            step = 0; repeat (3) @(negedge clk);
        end
        step = 1; repeat (hold) @(negedge clk);
        repeat (2) begin
            step = 0; repeat (3) @(negedge clk);
            step = 1; repeat (3) @(negedge clk);
        end
        step = 0; repeat (10) @(negedge clk);
    endtask

    // every cpu_ce pulse must match the oldest expected pulse
    always @(negedge clk) begin
        if (!reset) prev_ce = 0;
        else begin
            if (cpu_ce) begin
                chk("ce_consecutive", prev_ce, 0);
                if (sb.size() == 0) chk("ce_unexpected", cpu_ce, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("ce_state", state, mon_e.st);
                    chk("ce_cnt", cycle_cnt, mon_e.cnt);
                end
            end
            prev_ce = cpu_ce;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{'{3, 10, 1}, '{0, 3, 0}, '{0, 4, 1}, '{2, 2, 0}};
        #1 reset = 0;
        run = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            step = ~step;
            chk("rst_state", state, 0);
            chk("rst_ce", cpu_ce, 0);
            chk("rst_cnt", cycle_cnt, 0);
        end
        step = 0;
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        chk("run_entry_early", state, 0);
        @(negedge clk);
        chk("run_entry", state, 1);
        chk("busy_run", busy, 1);
        expect_pulses(2'd1, 10);
        repeat (3) @(negedge clk);
        chk("first_pulse_early", cpu_ce, 0);
        @(negedge clk);
        chk("first_pulse", cpu_ce, 1);
        repeat (36) @(negedge clk);
        run = 0;
        repeat (2) @(negedge clk);
        chk("run_drop_hold", state, 1);
        @(negedge clk);
        chk("run_drop_idle", state, 0);
        chk("busy_idle", busy, 0);
        repeat (4) @(negedge clk);
        sb_empty("run_pulses");
        chk("run_cnt", cycle_cnt, 10);

        run = 1;
        wait_state(2'd1, 10, "rerun");
        expect_pulses(2'd1, 1);
        repeat (4) @(negedge clk);
        chk("ce_before_reset", cpu_ce, 1);
        #2 reset = 0;
        #1;
        chk("ce_async", cpu_ce, 0);
        chk("state_async", state, 0);
        chk("cnt_async", cycle_cnt, 0);
        model_cnt = 0;
        run = 0;
        sb.delete();
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            expect_pulses(2'd2, vecs[i].exp_n);
            press(vecs[i].bounces, vecs[i].hold);
            sb_empty("step_pulses");
            chk("step_idle", state, 0);
            chk("step_cnt", cycle_cnt, model_cnt);
        end

        run = 1;
        wait_state(2'd1, 10, "halt_run");
        repeat (3) @(negedge clk);
        halt_req = 1;
        @(negedge clk);
        chk("halt_ce", cpu_ce, 0);
        chk("halt_state", state, 3);
        chk("busy_halt", busy, 0);
        repeat (5) @(negedge clk);
        chk("halt_hold", state, 3);
        expect_pulses(2'd2, 1);
        fork
            press(0, 10);
            begin
                wait_state(2'd2, 30, "halt_step");
                run = 0;
                halt_req = 0;
                @(negedge clk);
                chk("step_to_idle", state, 0);
            end
        join
        repeat (5) @(negedge clk);
        chk("halt_final", state, 0);
        sb_empty("halt_sb");

`ifdef BREAKPOINT_EN
        pc = 0; bp_addr = 32'hC; bp_valid = 1;
        expect_pulses(2'd1, 3);
        run = 1;
        wait_state(2'd1, 10, "bp_run");
        for (int i = 0; i < 24 && state != 3; i++) begin
            @(negedge clk);
            if (cpu_ce) pc = pc + 4;
        end
        chk("bp_halt", state, 3);
        chk("bp_pc", pc, 32'hC);
        chk("bp_ce", cpu_ce, 0);
        run = 0;
        wait_state(2'd0, 10, "bp_idle");
        expect_pulses(2'd1, 1);
        run = 1;
        wait_state(2'd1, 10, "bp_rerun");
        repeat (4) @(negedge clk);
        chk("bp_resume", cpu_ce, 1);
        pc = pc + 4;
        bp_addr = 32'h10;
        repeat (4) @(negedge clk);
        chk("bp_rehit_state", state, 3);
        chk("bp_rehit_ce", cpu_ce, 0);
        run = 0;
        wait_state(2'd0, 10, "bp_exit");
        sb_empty("bp_sb");
`else
        pc = 0; bp_addr = 0; bp_valid = 1;
        expect_pulses(2'd1, 3);
        run = 1;
        wait_state(2'd1, 10, "nobp_run");
        repeat (12) @(negedge clk);
        chk("nobp_state", state, 1);
        run = 0;
        wait_state(2'd0, 10, "nobp_idle");
        sb_empty("nobp_sb");
`endif

        reset = 0;
        sb.delete();
        @(negedge clk);
        reset = 1;
        model_cnt = 0;
        for (int p = 0; p < 17; p++) begin
            expect_pulses(2'd2, 1);
            press(0, 5);
            if (p == 15) chk("wrap_zero", cycle_cnt, 0);
        end
        chk("wrap_end", cycle_cnt, 1);
        sb_empty("wrap_sb");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
